// File: rtl/instr_register_pkg.sv
// ---------------------------------------------------------------------------
// instr_register_pkg
// Shared types and helpers for the instruction-register ALU.
//   operand_t     : signed 32-bit operand
//   address_t     : 5-bit register file index
//   result_t      : signed 64-bit result
//   opcode_t      : ZERO..MOD encoded 0..7 in 4 bits
//   instruction_t : {opc, operand_a, operand_b, rezultat} as stored per entry
//   calc_result   : result of every opcode that finishes in one cycle
//   is_div_op     : true for DIV and MOD
// No ports (package).
// ---------------------------------------------------------------------------
package instr_register_pkg;

    typedef logic signed [31:0] operand_t;
    typedef logic        [4:0]  address_t;
    typedef logic signed [63:0] result_t;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t operand_a;
        operand_t operand_b;
        result_t  rezultat;
    } instruction_t;

    localparam int NUM_ENTRIES = 2 ** $bits(address_t);
    localparam int DIV_ITER    = $bits(operand_t);

    // Operands are sign-extended to 64 bits first so ADD/SUB never overflow
    // and MULT yields the full product. DIV/MOD land in the default arm: this
    // covers the divide-by-zero case, which stores 0, as well as any opcode
    // value outside the enum.
    function automatic result_t calc_result(opcode_t op, operand_t a, operand_t b);
        result_t ra;
        result_t rb;
        result_t res;
        ra = result_t'(a);
        rb = result_t'(b);
        case (op)
            ZERO:    res = '0;
            PASSA:   res = ra;
            PASSB:   res = rb;
            ADD:     res = ra + rb;
            SUB:     res = ra - rb;
            MULT:    res = ra * rb;
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic logic is_div_op(opcode_t op);
        return (op == DIV) || (op == MOD);
    endfunction

endpackage

// File: rtl/instr_div_seq.sv
// ---------------------------------------------------------------------------
// instr_div_seq
// Iterative restoring divider, one quotient bit per clock, DIV_ITER steps.
// Operands are captured as magnitudes on start_i. The signs are re-applied
// combinationally on result_o once the iterations finish. The quotient
// truncates toward zero and the remainder follows the dividend's sign, which
// matches SystemVerilog / and %.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (aborts a division)
//   start_i      : capture a_i/b_i/is_mod_i and begin iterating
//   a_i, b_i     : signed dividend / divisor (b_i must be non-zero)
//   is_mod_i     : 1 = remainder, 0 = quotient
//   done_o       : high in the cycle whose rising edge performs the last step
//   result_o     : signed 64-bit result, valid from the edge after done_o
// ---------------------------------------------------------------------------
module instr_div_seq
    import instr_register_pkg::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     start_i,
    input  operand_t a_i,
    input  operand_t b_i,
    input  logic     is_mod_i,
    output logic     done_o,
    output result_t  result_o
);

    localparam int CNT_W = $clog2(DIV_ITER);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_ITER - 1);

    logic             running_q;
    logic [CNT_W-1:0] count_q;
    logic [31:0]      quo_q;
    logic [31:0]      rem_q;
    logic [31:0]      divisor_q;
    logic             negQuo_q;
    logic             negRem_q;
    logic             isMod_q;

    logic [31:0] magA;
    logic [31:0] magB;
    logic [32:0] remShift;
    logic [32:0] trial;
    logic [63:0] magResult;
    logic        negResult;

    // Two's-complement magnitudes. |-2^31| = 2^31 still fits in 32 unsigned bits.
    assign magA = a_i[31] ? (~a_i + 32'd1) : a_i;
    assign magB = b_i[31] ? (~b_i + 32'd1) : b_i;

    // A restoring step shifts the next dividend bit (the MSB of the quotient
    // register) into the partial remainder and then tries the subtraction.
    // If the subtraction borrows (bit 32 set), the step is undone.
    assign remShift = {rem_q, quo_q[31]};
    assign trial    = remShift - {1'b0, divisor_q};

    // Iteration state. The quotient register starts out holding the dividend
    // and fills with quotient bits from the LSB as the dividend bits are
    // consumed from the MSB.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            running_q <= 1'b0;
            count_q   <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            negQuo_q  <= 1'b0;
            negRem_q  <= 1'b0;
            isMod_q   <= 1'b0;
        end else if (start_i) begin
            running_q <= 1'b1;
            count_q   <= '0;
            quo_q     <= magA;
            rem_q     <= '0;
            divisor_q <= magB;
            negQuo_q  <= a_i[31] ^ b_i[31];
            negRem_q  <= a_i[31];
            isMod_q   <= is_mod_i;
        end else if (running_q) begin
            quo_q   <= {quo_q[30:0], ~trial[32]};
            rem_q   <= trial[32] ? remShift[31:0] : trial[31:0];
            count_q <= count_q + CNT_W'(1);
            if (count_q == LAST_STEP) begin
                running_q <= 1'b0;
            end
        end
    end

    assign done_o = running_q && (count_q == LAST_STEP);

    // Magnitudes are zero-extended before negation. A quotient of 2^31
    // (from -2^31 / -1) therefore stays positive in 64 bits instead of wrapping.
    assign magResult = isMod_q ? {32'd0, rem_q} : {32'd0, quo_q};
    assign negResult = isMod_q ? negRem_q : negQuo_q;
    assign result_o  = negResult ? result_t'(-magResult) : result_t'(magResult);

endmodule

// File: rtl/instr_register_alu.sv
// ---------------------------------------------------------------------------
// instr_register_alu
// Responder side of the instruction-register interface. An accepted write
// computes the result for the opcode and stores {opc, a, b, result} into one
// of NUM_ENTRIES registers. Entries are read back combinationally.
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   load_en          : write request, accepted on a rising edge when busy=0
//   opcode           : operation to store and execute
//   operand_a/b      : signed 32-bit operands
//   write_pointer    : destination entry
//   read_pointer     : entry presented on instruction_word
//   busy             : iterative division in progress, writes are ignored
//   instruction_word : contents of entry read_pointer
// Build option INSTR_REG_FAST_DIV_EN: when defined, DIV/MOD are computed in
// the write cycle and busy is tied low. When undefined, DIV/MOD with a
// non-zero divisor use instr_div_seq and hold busy high for 33 cycles.
// ---------------------------------------------------------------------------
module instr_register_alu
    import instr_register_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_en,
    input  opcode_t      opcode,
    input  operand_t     operand_a,
    input  operand_t     operand_b,
    input  address_t     write_pointer,
    input  address_t     read_pointer,
    output logic         busy,
    output instruction_t instruction_word
);

    instruction_t regFile_q [NUM_ENTRIES];

    logic         wrEn_d;
    address_t     wrAddr_d;
    instruction_t wrData_d;
    logic         accept;

    assign accept = load_en && !busy;

`ifdef INSTR_REG_FAST_DIV_EN

    result_t fastResult;

    // The full-width divide gives the same truncate-toward-zero quotient and
    // dividend-signed remainder as the iterative unit. It also keeps
    // -2^31 / -1 positive.
    always_comb begin
        fastResult = calc_result(opcode, operand_a, operand_b);
        if (is_div_op(opcode) && (operand_b != '0)) begin
            if (opcode == DIV) begin
                fastResult = result_t'(operand_a) / result_t'(operand_b);
            end else begin
                fastResult = result_t'(operand_a) % result_t'(operand_b);
            end
        end
    end

    assign busy = 1'b0;

    // Every accepted write lands in the register file on the same edge.
    always_comb begin
        wrEn_d             = accept;
        wrAddr_d           = write_pointer;
        wrData_d.opc       = opcode;
        wrData_d.operand_a = operand_a;
        wrData_d.operand_b = operand_b;
        wrData_d.rezultat  = fastResult;
    end

`else

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        WRITEBACK
    } state_t;

    state_t   state_q;
    logic     busy_q;
    opcode_t  pendOpc_q;
    operand_t pendA_q;
    operand_t pendB_q;
    address_t pendPtr_q;

    logic    startDiv;
    logic    divDone;
    result_t divResult;

    // Only a divide by a non-zero divisor needs the iterative unit. A zero
    // divisor is an ordinary single-cycle write that stores 0.
    assign startDiv = accept && is_div_op(opcode) && (operand_b != '0);

    instr_div_seq uDiv (
        .clk      (clk),
        .reset_n  (reset_n),
        .start_i  (startDiv),
        .a_i      (operand_a),
        .b_i      (operand_b),
        .is_mod_i (opcode == MOD),
        .done_o   (divDone),
        .result_o (divResult)
    );

    // Division sequencing. The instruction fields are captured on the
    // accepting edge, so the initiator may change its inputs while the
    // division runs. busy is registered: it rises after the accepting edge
    // and falls after the WRITEBACK edge, which gives exactly 33 busy cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            pendOpc_q <= ZERO;
            pendA_q   <= '0;
            pendB_q   <= '0;
            pendPtr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (startDiv) begin
                        state_q   <= DIVIDE;
                        busy_q    <= 1'b1;
                        pendOpc_q <= opcode;
                        pendA_q   <= operand_a;
                        pendB_q   <= operand_b;
                        pendPtr_q <= write_pointer;
                    end
                end
                DIVIDE: begin
                    if (divDone) begin
                        state_q <= WRITEBACK;
                    end
                end
                WRITEBACK: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;

    // Register file write selection. WRITEBACK and a fresh accept can never
    // coincide, because busy is still high during WRITEBACK.
    always_comb begin
        wrEn_d             = 1'b0;
        wrAddr_d           = write_pointer;
        wrData_d.opc       = opcode;
        wrData_d.operand_a = operand_a;
        wrData_d.operand_b = operand_b;
        wrData_d.rezultat  = calc_result(opcode, operand_a, operand_b);
        if (state_q == WRITEBACK) begin
            wrEn_d             = 1'b1;
            wrAddr_d           = pendPtr_q;
            wrData_d.opc       = pendOpc_q;
            wrData_d.operand_a = pendA_q;
            wrData_d.operand_b = pendB_q;
            wrData_d.rezultat  = divResult;
        end else if (accept && !startDiv) begin
            wrEn_d = 1'b1;
        end
    end

`endif

    // Register file storage. Reset clears every entry to {ZERO, 0, 0, 0}.
    // A write overwrites every field of the addressed entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                regFile_q[i] <= '0;
            end
        end else if (wrEn_d) begin
            regFile_q[wrAddr_d] <= wrData_d;
        end
    end

    // Combinational read. A same-address write becomes visible only after
    // its clock edge.
    assign instruction_word = regFile_q[read_pointer];

endmodule

// File: tb/tb_instr_register_alu.sv
// ---------------------------------------------------------------------------
// tb_instr_register_alu
// Self-checking bench for instr_register_alu. It keeps its own model of all
// 32 entries, with results computed from plain 64-bit integer arithmetic.
// ---------------------------------------------------------------------------
module tb_instr_register_alu;
    import instr_register_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         load_en;
    opcode_t      opcode;
    operand_t     operand_a;
    operand_t     operand_b;
    address_t     write_pointer;
    address_t     read_pointer;
    logic         busy;
    instruction_t instruction_word;

    int checks = 0;
    int errors = 0;

    instruction_t model [32];

    instr_register_alu dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .load_en          (load_en),
        .opcode           (opcode),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .write_pointer    (write_pointer),
        .read_pointer     (read_pointer),
        .busy             (busy),
        .instruction_word (instruction_word)
    );

    always #5 clk = ~clk;

    // Reference arithmetic in 64-bit integers. Native / and % already
    // truncate toward zero and give the remainder the dividend's sign.
    function automatic longint model_result(logic [3:0] op, int a, int b);
        longint la;
        longint lb;
        la = a;
        lb = b;
        case (op)
            4'd0:    return 0;
            4'd1:    return la;
            4'd2:    return lb;
            4'd3:    return la + lb;
            4'd4:    return la - lb;
            4'd5:    return la * lb;
            4'd6:    return (b == 0) ? 64'sd0 : la / lb;
            4'd7:    return (b == 0) ? 64'sd0 : la % lb;
            default: return 0;
        endcase
    endfunction

    function automatic instruction_t make_word(logic [3:0] op, int a, int b);
        instruction_t w;
        w.opc       = opcode_t'(op);
        w.operand_a = a;
        w.operand_b = b;
        w.rezultat  = model_result(op, a, b);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    task automatic drive(logic [3:0] op, int a, int b, logic [4:0] addr);
        opcode        = opcode_t'(op);
        operand_a     = a;
        operand_b     = b;
        write_pointer = addr;
        load_en       = 1'b1;
    endtask

    // Single-cycle write: accepted on the next edge.
    task automatic write_single(logic [3:0] op, int a, int b, logic [4:0] addr);
        drive(op, a, b, addr);
        tick();
        load_en = 1'b0;
        model[addr] = make_word(op, a, b);
    endtask

    // Iterative divide: counts the busy cycles (bounded) after acceptance.
    task automatic run_div(logic [3:0] op, int a, int b, logic [4:0] addr, output int cycles);
        drive(op, a, b, addr);
        tick();
        load_en = 1'b0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 100) begin
            cycles++;
            tick();
        end
        model[addr] = make_word(op, a, b);
    endtask

    task automatic test_reset();
        load_en = 1'b0;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        clear_model();
        tick();
        for (int i = 0; i < 32; i++) begin
            read_pointer = 5'(i);
            #1;
            checks++;
            if (instruction_word !== '0) begin
                errors++;
                $display("[TB] FAIL reset_entry[%0d]: got %h expected 0", i, instruction_word);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_add();
        read_pointer = 5'd5;
        drive(4'd3, 7, -3, 5'd5);
        #1;
        checks++;
        if (instruction_word !== model[5]) begin
            errors++;
            $display("[TB] FAIL read_before_write: got %h expected %h", instruction_word, model[5]);
        end
        tick();
        load_en = 1'b0;
        model[5] = make_word(4'd3, 7, -3);
        checks++;
        if (instruction_word !== model[5] || instruction_word.rezultat !== 64'sd4) begin
            errors++;
            $display("[TB] FAIL add_word: got %h expected %h", instruction_word, model[5]);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_mult_sub();
        write_single(4'd5, -15, 15, 5'd31);
        write_single(4'd4, 0, 15, 5'd0);
        read_pointer = 5'd31;
        #1;
        checks++;
        if (instruction_word !== model[31] || instruction_word.rezultat !== -64'sd225) begin
            errors++;
            $display("[TB] FAIL mult_word: got %h expected %h", instruction_word, model[31]);
        end
        read_pointer = 5'd0;
        #1;
        checks++;
        if (instruction_word !== model[0] || instruction_word.rezultat !== -64'sd15) begin
            errors++;
            $display("[TB] FAIL sub_word: got %h expected %h", instruction_word, model[0]);
        end
    endtask

    task automatic test_div();
        int cyc;
        logic [3:0] ops [3] = '{4'd6, 4'd7, 4'd6};
        int as [3] = '{-15, -15, 32'sh8000_0000};
        int bs [3] = '{4, 4, -1};
        logic [4:0] addrs [3] = '{5'd3, 5'd4, 5'd6};
        longint exps [3] = '{-3, -3, 64'sd2147483648};
        for (int i = 0; i < 3; i++) begin
            run_div(ops[i], as[i], bs[i], addrs[i], cyc);
            checks++;
            if (cyc != 33) begin
                errors++;
                $display("[TB] FAIL div_busy_len[%0d]: got %0d cycles expected 33", i, cyc);
            end
            read_pointer = addrs[i];
            #1;
            checks++;
            if (instruction_word !== model[addrs[i]] || instruction_word.rezultat !== exps[i]) begin
                errors++;
                $display("[TB] FAIL div_word[%0d]: got %h expected %h", i, instruction_word, model[addrs[i]]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int cyc;
        drive(4'd6, 100, -7, 5'd3);
        tick();
        load_en = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ignore_busy_high: got %b expected 1", busy);
        end
        drive(4'd1, 9, 0, 5'd3);
        tick();
        load_en = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            tick();
        end
        checks++;
        if (cyc >= 100) begin
            errors++;
            $display("[TB] FAIL ignore_busy_timeout: got %0d cycles expected under 100", cyc);
        end
        model[3] = make_word(4'd6, 100, -7);
        read_pointer = 5'd3;
        #1;
        checks++;
        if (instruction_word !== model[3] || instruction_word.rezultat !== -64'sd14) begin
            errors++;
            $display("[TB] FAIL ignore_kept_div: got %h expected %h", instruction_word, model[3]);
        end
        write_single(4'd1, 9, 0, 5'd3);
        checks++;
        if (instruction_word !== model[3] || instruction_word.rezultat !== 64'sd9) begin
            errors++;
            $display("[TB] FAIL retry_passa: got %h expected %h", instruction_word, model[3]);
        end
    endtask

    task automatic test_reset_abort();
        drive(4'd6, 1000, 3, 5'd8);
        tick();
        load_en = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_busy_before: got %b expected 1", busy);
        end
        reset_n = 1'b0;
        clear_model();
        read_pointer = 5'd8;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_busy_drop: got %b expected 0", busy);
        end
        checks++;
        if (instruction_word !== '0) begin
            errors++;
            $display("[TB] FAIL abort_entry_now: got %h expected 0", instruction_word);
        end
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        checks++;
        if (instruction_word !== '0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_entry_later: got %h busy %b expected 0 busy 0", instruction_word, busy);
        end
        read_pointer = 5'd9;
        write_single(4'd6, 5, 0, 5'd9);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL div0_busy: got %b expected 0", busy);
        end
        checks++;
        if (instruction_word !== model[9] || instruction_word.rezultat !== 64'sd0) begin
            errors++;
            $display("[TB] FAIL div0_word: got %h expected %h", instruction_word, model[9]);
        end
    endtask

    task automatic test_random();
        int cyc;
        for (int n = 0; n < 24; n++) begin
            logic [3:0] op;
            int a;
            int b;
            op = 4'($urandom_range(0, 15));
            a  = int'($urandom);
            b  = int'($urandom);
            if (op == 4'd6 || op == 4'd7) b = 0;
            write_single(op, a, b, 5'($urandom_range(0, 31)));
        end
        for (int n = 0; n < 4; n++) begin
            logic [4:0] addr;
            int a;
            int b;
            addr = 5'($urandom_range(0, 31));
            a = int'($urandom);
            b = (n < 2) ? int'($urandom_range(1, 20)) : int'($urandom);
            if (b == 0) b = 1;
            if ($urandom_range(0, 1) == 1) b = -b;
            run_div((n % 2 == 0) ? 4'd6 : 4'd7, a, b, addr, cyc);
            checks++;
            if (cyc != 33) begin
                errors++;
                $display("[TB] FAIL rand_div_len[%0d]: got %0d cycles expected 33", n, cyc);
            end
        end
        for (int i = 0; i < 32; i++) begin
            read_pointer = 5'(i);
            #1;
            checks++;
            if (instruction_word !== model[i]) begin
                errors++;
                $display("[TB] FAIL rand_entry[%0d]: got %h expected %h", i, instruction_word, model[i]);
            end
        end
    endtask

    // Runs the scenarios in sequence, then prints the summary.
    initial begin
        reset_n       = 1'b0;
        load_en       = 1'b0;
        opcode        = ZERO;
        operand_a     = '0;
        operand_b     = '0;
        write_pointer = '0;
        read_pointer  = '0;
        clear_model();
        #2;
        test_reset();
        test_add();
        test_mult_sub();
        test_div();
        test_busy_ignore();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
